parallel_cmd_engine: RTL and testbench



---
 rtl/parallel_cmd_engine.sv | 112 +++++++++++
 tb/tb_parallel_cmd_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/parallel_cmd_engine.sv
// Byte-oriented command engine behind the parallel pin transceiver.
// Pi write bursts go into a small register file, and read bursts stream it back out.
module parallel_cmd_engine #(
  parameter int ADDR_BITS = 4,
  parameter int DEPTH     = 2**ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 chip_select,
  input  logic [7:0]           rx_byte,
  output logic [7:0]           tx_byte,
  output logic [8*DEPTH-1:0]   regs_flat,
  output logic                 wr_pulse,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 busy
);

  // state   | meaning
  // IDLE    | waiting for a command byte
  // WR      | storing consumed bytes at pointer, auto-increment
  // RD_ARM  | read command seen, waiting for chip_select to drop
  // RD      | driving reg[pointer] each cycle chip_select is low
  // DISCARD | bad command, ignore the rest of the high phase
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ARM,
    RD,
    DISCARD
  } state_t;

  state_t               state;
  logic                 cs_q;
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           regs [DEPTH];
  logic                 consume;

  // The transceiver latched rx_byte on the falling edge between these two high samples.
  assign consume = cs_q & chip_select;
  assign busy    = (state != IDLE);

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_flat[8*i +: 8] = regs[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      cs_q     <= 1'b0;
      ptr      <= '0;
      tx_byte  <= 8'h00;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      cs_q     <= chip_select;
      wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (consume) begin
            ptr <= rx_byte[ADDR_BITS-1:0];
            if (rx_byte[6:ADDR_BITS] != '0) begin
              state <= DISCARD;
            end else if (rx_byte[7]) begin
              state <= WR;
            end else begin
              state <= RD_ARM;
            end
          end
        end
        WR: begin
          // chip_select edges take priority over byte consumption.
          if (!chip_select) begin
            state <= IDLE;
          end else if (consume) begin
            regs[ptr] <= rx_byte;
            wr_pulse  <= 1'b1;
            wr_addr   <= ptr;
            ptr       <= ptr + 1'b1;
          end
        end
        RD_ARM: begin
          if (!chip_select) begin
            tx_byte <= regs[ptr];
            ptr     <= ptr + 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          if (chip_select) begin
            state <= IDLE;
          end else begin
            tx_byte <= regs[ptr];
            ptr     <= ptr + 1'b1;
          end
        end
        DISCARD: begin
          if (!chip_select) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_cmd_engine.sv
// Directed bench for parallel_cmd_engine: write, wrap, read, bad command, reset mid-burst.
module tb_parallel_cmd_engine;

  localparam int ADDR_BITS = 4;
  localparam int DEPTH     = 16;

  logic                 clock;
  logic                 reset_n;
  logic                 chip_select;
  logic [7:0]           rx_byte;
  logic [7:0]           tx_byte;
  logic [8*DEPTH-1:0]   regs_flat;
  logic                 wr_pulse;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 busy;

  logic [8*DEPTH-1:0]   exp_regs;
  int                   total;
  int                   fails;

  parallel_cmd_engine #(.ADDR_BITS(ADDR_BITS)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .chip_select (chip_select),
    .rx_byte     (rx_byte),
    .tx_byte     (tx_byte),
    .regs_flat   (regs_flat),
    .wr_pulse    (wr_pulse),
    .wr_addr     (wr_addr),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle's inputs at a falling edge; return at the next falling edge.
  task automatic cyc(input logic cs, input logic [7:0] b);
    chip_select = cs;
    rx_byte     = b;
    @(negedge clock);
  endtask

  task automatic set_exp(input int idx, input logic [7:0] v);
    exp_regs[8*idx +: 8] = v;
  endtask

  initial begin
    total       = 0;
    fails       = 0;
    exp_regs    = '0;
    reset_n     = 1'b0;
    chip_select = 1'b0;
    rx_byte     = 8'h00;
    @(negedge clock);
    @(negedge clock);

    check("rst_regs", regs_flat, exp_regs);
    check("rst_tx", tx_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    reset_n = 1'b1;

    // Write burst at 3
    cyc(1'b1, 8'h00);
    check("wb_first_edge_idle", busy, 1'b0);
    cyc(1'b1, 8'h83);
    check("wb_cmd_busy", busy, 1'b1);
    check("wb_cmd_no_pulse", wr_pulse, 1'b0);
    cyc(1'b1, 8'hAA);
    set_exp(3, 8'hAA);
    check("wb_pulse0", wr_pulse, 1'b1);
    check("wb_addr0", wr_addr, 4'd3);
    check("wb_regs0", regs_flat, exp_regs);
    cyc(1'b1, 8'hBB);
    set_exp(4, 8'hBB);
    check("wb_pulse1", wr_pulse, 1'b1);
    check("wb_addr1", wr_addr, 4'd4);
    cyc(1'b1, 8'hCC);
    set_exp(5, 8'hCC);
    check("wb_pulse2", wr_pulse, 1'b1);
    check("wb_addr2", wr_addr, 4'd5);
    cyc(1'b0, 8'h00);
    check("wb_end_idle", busy, 1'b0);
    check("wb_end_no_pulse", wr_pulse, 1'b0);
    check("wb_end_regs", regs_flat, exp_regs);

    // Write wrap 15 -> 0
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h8F);
    cyc(1'b1, 8'h11);
    set_exp(15, 8'h11);
    check("ww_addr15", wr_addr, 4'd15);
    cyc(1'b1, 8'h22);
    set_exp(0, 8'h22);
    check("ww_addr0", wr_addr, 4'd0);
    check("ww_pulse", wr_pulse, 1'b1);
    cyc(1'b0, 8'h00);
    check("ww_regs", regs_flat, exp_regs);

    // Read burst from 3, with a stray byte during RD_ARM
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h03);
    check("rd_arm_busy", busy, 1'b1);
    cyc(1'b1, 8'h77);
    check("rd_arm_no_pulse", wr_pulse, 1'b0);
    cyc(1'b0, 8'h00);
    check("rd_tx0", tx_byte, 8'hAA);
    cyc(1'b0, 8'h00);
    check("rd_tx1", tx_byte, 8'hBB);
    cyc(1'b0, 8'h00);
    check("rd_tx2", tx_byte, 8'hCC);
    cyc(1'b1, 8'h00);
    check("rd_end_idle", busy, 1'b0);
    check("rd_end_tx_hold", tx_byte, 8'hCC);
    check("rd_regs_unchanged", regs_flat, exp_regs);
    cyc(1'b0, 8'h00);
    check("idle_cs_low_tx_hold", tx_byte, 8'hCC);

    // Read wrap 15 -> 0
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h0F);
    cyc(1'b0, 8'h00);
    check("rw_tx15", tx_byte, 8'h11);
    cyc(1'b0, 8'h00);
    check("rw_tx0", tx_byte, 8'h22);
    cyc(1'b1, 8'h00);
    check("rw_end_idle", busy, 1'b0);

    // Reserved bits set -> discard
    cyc(1'b1, 8'h90);
    check("rsv_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h55);
      check("rsv_no_pulse", wr_pulse, 1'b0);
    end
    cyc(1'b0, 8'h00);
    check("rsv_end_idle", busy, 1'b0);
    check("rsv_regs", regs_flat, exp_regs);

    // Reset in the middle of a write burst at 6
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h86);
    cyc(1'b1, 8'hD1);
    cyc(1'b1, 8'hD2);
    set_exp(6, 8'hD1);
    set_exp(7, 8'hD2);
    check("rm_pre_regs", regs_flat, exp_regs);
    reset_n = 1'b0;
    cyc(1'b1, 8'hD3);
    exp_regs = '0;
    check("rm_regs_cleared", regs_flat, exp_regs);
    check("rm_idle", busy, 1'b0);
    check("rm_tx", tx_byte, 8'h00);
    check("rm_no_pulse", wr_pulse, 1'b0);
    reset_n = 1'b1;
    cyc(1'b1, 8'hD4);
    cyc(1'b1, 8'hD5);
    cyc(1'b1, 8'hD6);
    check("rm_after_no_pulse", wr_pulse, 1'b0);
    cyc(1'b0, 8'h00);
    check("rm_after_regs", regs_flat, exp_regs);
    check("rm_after_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
